// File: rtl/spi_master_tx10_if.sv
// spi_master_tx10_if: parallel request/reply and SPI pin bundle for spi_master_tx10
interface spi_master_tx10_if #(
    parameter int WIDTH = 10
);
    logic             i_start;
    logic [WIDTH-1:0] i_data_in;
    logic             i_miso;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_data_out;
    logic             o_sclk;
    logic             o_cs_n;
    logic             o_mosi;

    modport master (
        input  i_start, i_data_in, i_miso,
        output o_busy, o_done, o_data_out, o_sclk, o_cs_n, o_mosi
    );

    modport slave (
        output i_start, i_data_in, i_miso,
        input  o_busy, o_done, o_data_out, o_sclk, o_cs_n, o_mosi
    );
endinterface

// File: rtl/spi_master_tx10.sv
// spi_master_tx10: mode-0 SPI master, full-duplex WIDTH-bit frames, MSB first
module spi_master_tx10 #(
    parameter int WIDTH   = 10,
    parameter int CLK_DIV = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    spi_master_tx10_if.master  bus
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EW = $clog2(2 * WIDTH);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    state_t           r_state, w_next;
    logic [DW-1:0]    r_div;
    logic [EW-1:0]    r_edge;
    logic [WIDTH-1:0] r_tx, r_rx, r_data_out;
    logic             r_sclk, r_cs_n, r_busy, r_done;
    logic             w_hp_end, w_last, w_active, w_accept, w_frame;

    assign w_hp_end = r_div == DW'(CLK_DIV - 1);
    assign w_last   = r_edge == EW'(2 * WIDTH - 1);
    assign w_frame  = r_state inside {SETUP, SHIFT, HOLD};
    assign w_accept = bus.i_start && (r_state == IDLE || r_state == DONE);
    assign w_active = w_next inside {SETUP, SHIFT, HOLD};

    // Next-state: each timed phase advances when its half-period counter expires
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.i_start ? SETUP : IDLE;
            SETUP:   w_next = w_hp_end ? SHIFT : SETUP;
            SHIFT:   w_next = (w_hp_end && w_last) ? HOLD : SHIFT;
            HOLD:    w_next = w_hp_end ? DONE : HOLD;
            DONE:    w_next = bus.i_start ? SETUP : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Datapath: counters, shift registers and registered pin/status outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div      <= '0;
            r_edge     <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_data_out <= '0;
            r_sclk     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_div  <= (w_frame && !w_hp_end) ? r_div + 1'b1 : '0;
            r_cs_n <= !w_active;
            r_busy <= w_active;
            r_done <= r_state == DONE;
            if (r_state == DONE) r_data_out <= r_rx;
            if (w_accept) r_tx <= bus.i_data_in;
            if (r_state == SHIFT && w_hp_end) begin
                r_sclk <= !r_sclk;
                r_edge <= w_last ? '0 : r_edge + 1'b1;
                if (!r_sclk) r_rx <= {r_rx[WIDTH-2:0], bus.i_miso};
                else if (!w_last) r_tx <= {r_tx[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign bus.o_busy     = r_busy;
    assign bus.o_done     = r_done;
    assign bus.o_data_out = r_data_out;
    assign bus.o_sclk     = r_sclk;
    assign bus.o_cs_n     = r_cs_n;
    assign bus.o_mosi     = r_tx[WIDTH-1];
endmodule
